// File: rtl/magnitude_sequencer_if.sv
// rtl/magnitude_sequencer_if.sv - sample RAM, magnitude unit and spectrum RAM signal bundle
interface magnitude_sequencer_if #(
  parameter int ADDR_W = 14,
  parameter int BIN_W  = 13,
  parameter int DATA_W = 25,
  parameter int MAG_W  = 13
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              sm_ready;
  logic              sm_enable;
  logic              sm_done;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic [MAG_W-1:0]  result;
  logic              mag_wr_en;
  logic [BIN_W-1:0]  mag_wr_addr;
  logic [MAG_W-1:0]  mag_wr_data;

  modport master (
    output ram_rd_en, ram_rd_addr,
    input  ram_rd_data,
    output sm_ready, sm_enable, sm_done, source_real, source_imag,
    input  result,
    output mag_wr_en, mag_wr_addr, mag_wr_data
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr,
    output ram_rd_data,
    input  sm_ready, sm_enable, sm_done, source_real, source_imag,
    output result,
    input  mag_wr_en, mag_wr_addr, mag_wr_data
  );
endinterface

// File: rtl/magnitude_sequencer.sv
// rtl/magnitude_sequencer.sv - sequences the magnitude unit over one FFT frame and tracks the peak bin
module magnitude_sequencer #(
  parameter int N_BINS  = 8192,
  parameter int ADDR_W  = 14,
  parameter int BIN_W   = 13,
  parameter int DATA_W  = 25,
  parameter int MAG_W   = 13,
  parameter int MAG_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [BIN_W-1:0]     peak_bin,
  output logic [MAG_W-1:0]     peak_mag,
  magnitude_sequencer_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 * N_BINS - 1);
  localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(N_BINS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              rd_en;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_vld_q;
  logic              rd_odd_q;
  logic [DATA_W-1:0] real_hold_q;
  logic [DATA_W-1:0] src_real_q;
  logic [DATA_W-1:0] src_imag_q;
  logic              strobe_q;
  logic [BIN_W-1:0]  bin_cnt_q;
  logic [BIN_W-1:0]  strobe_bin_q;
  logic              sm_done_q;

  logic [MAG_LAT-1:0] pipe_vld_q;
  logic [BIN_W-1:0]   pipe_bin_q [MAG_LAT];
  logic               wr_vld;
  logic [BIN_W-1:0]   wr_bin;
  logic [MAG_W-1:0]   wr_data;

  logic [BIN_W-1:0]   peak_bin_q;
  logic [MAG_W-1:0]   peak_mag_q;

  // Tail of the latency pipe lines up with the magnitude unit's result
  assign wr_vld  = pipe_vld_q[MAG_LAT-1];
  assign wr_bin  = pipe_bin_q[MAG_LAT-1];
  assign wr_data = wr_vld ? bus.result : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    rd_en      = 1'b0;
    busy       = (state_q != IDLE);
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_vld && wr_bin == LAST_BIN) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample RAM address walk; parity of the address rides along with the 1-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_odd_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      rd_odd_q <= rd_addr_q[0];
      if (accept)
        rd_addr_q <= '0;
      else if (rd_en && rd_addr_q != LAST_ADDR)
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
    end
  end

  // Operand assembly: hold the real word, strobe the pair when the imag word lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      real_hold_q  <= '0;
      src_real_q   <= '0;
      src_imag_q   <= '0;
      strobe_q     <= 1'b0;
      bin_cnt_q    <= '0;
      strobe_bin_q <= '0;
      sm_done_q    <= 1'b0;
    end else begin
      strobe_q  <= rd_vld_q && rd_odd_q;
      sm_done_q <= strobe_q && (strobe_bin_q == LAST_BIN);
      if (accept) begin
        bin_cnt_q <= '0;
      end else if (rd_vld_q && !rd_odd_q) begin
        real_hold_q <= bus.ram_rd_data;
      end else if (rd_vld_q && rd_odd_q) begin
        src_real_q   <= real_hold_q;
        src_imag_q   <= bus.ram_rd_data;
        strobe_bin_q <= bin_cnt_q;
        bin_cnt_q    <= bin_cnt_q + BIN_W'(1);
      end
    end
  end

  // Latency pipe carrying (valid, bin) from each strobe to its result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < MAG_LAT; i++) pipe_bin_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= strobe_q;
      pipe_bin_q[0] <= strobe_bin_q;
      for (int i = 1; i < MAG_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_bin_q[i] <= pipe_bin_q[i-1];
      end
    end
  end

  // Peak tracking: strict compare so ties keep the earliest bin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (accept) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (wr_vld && bus.result > peak_mag_q) begin
      peak_bin_q <= wr_bin;
      peak_mag_q <= bus.result;
    end
  end

  assign peak_bin        = peak_bin_q;
  assign peak_mag        = peak_mag_q;
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_addr_q;
  assign bus.sm_ready    = busy;
  assign bus.sm_enable   = strobe_q;
  assign bus.sm_done     = sm_done_q;
  assign bus.source_real = src_real_q;
  assign bus.source_imag = src_imag_q;
  assign bus.mag_wr_en   = wr_vld;
  assign bus.mag_wr_addr = wr_bin;
  assign bus.mag_wr_data = wr_data;
endmodule

// File: tb/tb_magnitude_sequencer.sv
// tb/tb_magnitude_sequencer.sv - directed bench for magnitude_sequencer with RAM and magnitude models
module tb_magnitude_sequencer;
  localparam int N_BINS  = 4;
  localparam int ADDR_W  = 3;
  localparam int BIN_W   = 2;
  localparam int DATA_W  = 25;
  localparam int MAG_W   = 13;
  localparam int MAG_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done;
  logic [BIN_W-1:0] peak_bin;
  logic [MAG_W-1:0] peak_mag;

  magnitude_sequencer_if #(.ADDR_W(ADDR_W), .BIN_W(BIN_W), .DATA_W(DATA_W), .MAG_W(MAG_W)) ifc ();

  magnitude_sequencer #(
    .N_BINS(N_BINS), .ADDR_W(ADDR_W), .BIN_W(BIN_W),
    .DATA_W(DATA_W), .MAG_W(MAG_W), .MAG_LAT(MAG_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .bus(ifc)
  );

  always #5 clk = ~clk;

  // Sample RAM model, registered read
  logic [DATA_W-1:0] ram [2*N_BINS];
  logic [DATA_W-1:0] ram_q = '0;
  always @(posedge clk) if (ifc.ram_rd_en) ram_q <= ram[ifc.ram_rd_addr];
  assign ifc.ram_rd_data = ram_q;

  // Magnitude model: |re|+|im| saturated, two-cycle latency
  function automatic logic [MAG_W-1:0] mag_of(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
    int a, b, s;
    a = int'($signed(re));
    b = int'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    s = a + b;
    if (s > 8191) s = 8191;
    return MAG_W'(s);
  endfunction
  logic [MAG_W-1:0] mp0 = '0, mp1 = '0;
  always @(posedge clk) begin
    mp0 <= ifc.sm_enable ? mag_of(ifc.source_real, ifc.source_imag) : '0;
    mp1 <= mp0;
  end
  assign ifc.result = mp1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recording
  bit busy_at [2048];
  int rdy_err = 0;
  int st_cyc[$], st_re[$], st_im[$];
  int wr_cyc[$], wr_addr[$], wr_data[$];
  int rd_cyc[$], rd_addr[$];
  int fd_cyc[$], sd_cyc[$];
  always @(negedge clk) begin
    if (cyc < 2048) busy_at[cyc] = busy;
    if (ifc.sm_ready !== busy) rdy_err++;
    if (ifc.sm_enable) begin
      st_cyc.push_back(cyc); st_re.push_back(int'(ifc.source_real)); st_im.push_back(int'(ifc.source_imag));
    end
    if (ifc.mag_wr_en) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(int'(ifc.mag_wr_addr)); wr_data.push_back(int'(ifc.mag_wr_data));
    end
    if (ifc.ram_rd_en) begin
      rd_cyc.push_back(cyc); rd_addr.push_back(int'(ifc.ram_rd_addr));
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (ifc.sm_done) sd_cyc.push_back(cyc);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int exp_re [N_BINS];
  int exp_im [N_BINS];
  int exp_mag [N_BINS];

  function automatic int w(input int v);
    return v & 32'h01FF_FFFF;
  endfunction

  task automatic set_bin(input int k, input int re, input int im, input int mag);
    ram[2*k]   = DATA_W'(re);
    ram[2*k+1] = DATA_W'(im);
    exp_re[k]  = w(re);
    exp_im[k]  = w(im);
    exp_mag[k] = mag;
  endtask

  task automatic clear_log();
    st_cyc.delete(); st_re.delete(); st_im.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rd_cyc.delete(); rd_addr.delete();
    fd_cyc.delete(); sd_cyc.delete();
  endtask

  task automatic do_start(output int b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = cyc;
  endtask

  task automatic check_frame(input string nm, input int b, input int pbin, input int pmag);
    check({nm, "_strobes"}, st_cyc.size(), N_BINS);
    for (int k = 0; k < N_BINS && k < st_cyc.size(); k++) begin
      check($sformatf("%s_st%0d_cyc", nm, k), st_cyc[k] - b, 2*k + 3);
      check($sformatf("%s_st%0d_re", nm, k), st_re[k], exp_re[k]);
      check($sformatf("%s_st%0d_im", nm, k), st_im[k], exp_im[k]);
    end
    check({nm, "_writes"}, wr_cyc.size(), N_BINS);
    for (int k = 0; k < N_BINS && k < wr_cyc.size(); k++) begin
      check($sformatf("%s_wr%0d_cyc", nm, k), wr_cyc[k] - b, 2*k + 3 + MAG_LAT);
      check($sformatf("%s_wr%0d_addr", nm, k), wr_addr[k], k);
      check($sformatf("%s_wr%0d_data", nm, k), wr_data[k], exp_mag[k]);
    end
    check({nm, "_sm_done_n"}, sd_cyc.size(), 1);
    if (sd_cyc.size() > 0) check({nm, "_sm_done_cyc"}, sd_cyc[0] - b, 10);
    check({nm, "_fd_n"}, fd_cyc.size(), 1);
    if (fd_cyc.size() > 0) check({nm, "_fd_cyc"}, fd_cyc[0] - b, 12);
    check({nm, "_busy_e0"}, int'(busy_at[b]), 1);
    check({nm, "_busy_e12"}, int'(busy_at[b+12]), 1);
    check({nm, "_busy_e13"}, int'(busy_at[b+13]), 0);
    check({nm, "_peak_bin"}, int'(peak_bin), pbin);
    check({nm, "_peak_mag"}, int'(peak_mag), pmag);
  endtask

  task automatic load_t1();
    set_bin(0, 3, 4, 7); set_bin(1, 10, 0, 10); set_bin(2, 0, 7, 7); set_bin(3, 1, 1, 2);
  endtask

  int b;
  int nw;

  initial begin
    for (int i = 0; i < 2*N_BINS; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_peak", int'(peak_mag), 0);
    check("rst_wr_en", int'(ifc.mag_wr_en), 0);

    // Single frame
    load_t1();
    clear_log();
    do_start(b);
    repeat (20) @(negedge clk);
    check_frame("f1", b, 1, 10);

    // Tie frame: 5,9,9,3 with a negative operand
    set_bin(0, 5, 0, 5); set_bin(1, -4, 5, 9); set_bin(2, 9, 0, 9); set_bin(3, 0, 3, 3);
    clear_log();
    do_start(b);
    repeat (20) @(negedge clk);
    check_frame("tie", b, 1, 9);

    // start pulse mid-frame is ignored
    load_t1();
    clear_log();
    do_start(b);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check_frame("mid", b, 1, 10);
    check("mid_reads", rd_cyc.size(), 2*N_BINS);
    for (int i = 0; i < 2*N_BINS && i < rd_cyc.size(); i++) begin
      check($sformatf("mid_rd%0d_addr", i), rd_addr[i], i);
      check($sformatf("mid_rd%0d_cyc", i), rd_cyc[i] - b, i);
    end

    // Reset mid-frame
    clear_log();
    do_start(b);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rr_ctrl", int'({busy, frame_done, ifc.ram_rd_en, ifc.sm_ready, ifc.sm_enable,
                           ifc.sm_done, ifc.mag_wr_en}), 0);
    check("rr_data", int'(|{ifc.ram_rd_addr, ifc.source_real, ifc.source_imag,
                            ifc.mag_wr_addr, ifc.mag_wr_data}), 0);
    check("rr_peak", int'({peak_bin, peak_mag}), 0);
    nw = wr_cyc.size();
    check("rr_writes_before", nw, 2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rr_writes_after", wr_cyc.size(), nw);
    check("rr_no_fd", fd_cyc.size(), 0);
    check("rr_peak_after", int'(peak_mag), 0);
    check("rr_idle", int'(busy), 0);
    set_bin(0, 5, 0, 5); set_bin(1, -4, 5, 9); set_bin(2, 9, 0, 9); set_bin(3, 0, 3, 3);
    clear_log();
    do_start(b);
    repeat (20) @(negedge clk);
    check_frame("rr_new", b, 1, 9);

    // start held: three frames, RAM changed between frames
    set_bin(0, 0, 0, 0); set_bin(1, 0, 0, 0); set_bin(2, 0, 0, 0); set_bin(3, 2, -6, 8);
    clear_log();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    b = cyc;
    for (int r = 1; r <= 44; r++) begin
      @(negedge clk);
      if (r == 10) begin
        for (int k = 0; k < N_BINS; k++) set_bin(k, 0, 0, 0);
      end
      if (r == 24) load_t1();
      if (r == 12) begin
        check("held_f1_peak_bin", int'(peak_bin), 3);
        check("held_f1_peak_mag", int'(peak_mag), 8);
      end
      if (r == 26) begin
        check("held_f2_peak_bin", int'(peak_bin), 0);
        check("held_f2_peak_mag", int'(peak_mag), 0);
      end
      if (r == 40) begin
        check("held_f3_peak_bin", int'(peak_bin), 1);
        check("held_f3_peak_mag", int'(peak_mag), 10);
        start = 1'b0;
      end
    end
    check("held_fd_n", fd_cyc.size(), 3);
    for (int i = 0; i < 3 && i < fd_cyc.size(); i++)
      check($sformatf("held_fd%0d_cyc", i), fd_cyc[i] - b, 12 + 14*i);
    check("held_writes", wr_cyc.size(), 3*N_BINS);
    if (wr_cyc.size() == 3*N_BINS) begin
      check("held_f1_last_data", wr_data[3], 8);
      check("held_f2_last_data", wr_data[7], 0);
      check("held_f3_bin1_data", wr_data[9], 10);
      check("held_f3_last_addr", wr_addr[11], 3);
    end
    check("held_gap1_low", int'(busy_at[b+13]), 0);
    check("held_gap1_high", int'(busy_at[b+14]), 1);
    check("held_gap2_low", int'(busy_at[b+27]), 0);
    check("held_gap2_high", int'(busy_at[b+28]), 1);
    check("held_end_idle", int'(busy_at[b+43]), 0);
    check("sm_ready_tracks_busy", rdy_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
